// File: rtl/multicycle_cpu.sv
// Multi-cycle MIPS-subset CPU: FETCH/DECODE/EXEC/MEM/WB over req/ack memory ports.
// Optional feature: define MCPU_BNE_EN to make opcode 0x05 (bne) legal.
module multicycle_cpu #(
  parameter int                ADDR_W   = 32,
  parameter int                NUM_REGS = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [31:0]       imem_rdata,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [31:0]       dmem_wdata,
  input  logic              dmem_ack,
  input  logic [31:0]       dmem_rdata,
  output logic [ADDR_W-1:0] pc,
  output logic              retire,
  output logic              halted
);

  // Handshake: a request is raised together with stable addr/wdata and held
  // unchanged until ack is sampled high on a rising edge; it drops the next cycle.

  localparam int RW = $clog2(NUM_REGS);

`ifdef MCPU_BNE_EN
  localparam bit BNE_EN = 1'b1;
`else
  localparam bit BNE_EN = 1'b0;
`endif

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] F_SRL = 6'h02;
  localparam logic [5:0] F_ADD = 6'h20;
  localparam logic [5:0] F_SUB = 6'h22;
  localparam logic [5:0] F_AND = 6'h24;
  localparam logic [5:0] F_OR  = 6'h25;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  state_t      state;
  logic [31:0] rf [NUM_REGS];
  logic [31:0] ir;
  logic [31:0] a_reg;
  logic [31:0] b_reg;
  logic [31:0] alu_out;
  logic [31:0] mdr;

  logic [5:0]  opcode;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic [4:0]  shamt;
  logic [5:0]  funct;
  logic [31:0] sext_imm;
  logic [31:0] zext_imm;

  assign opcode   = ir[31:26];
  assign rs       = ir[25:21];
  assign rt       = ir[20:16];
  assign rd       = ir[15:11];
  assign shamt    = ir[10:6];
  assign funct    = ir[5:0];
  assign sext_imm = {{16{ir[15]}}, ir[15:0]};
  assign zext_imm = {16'h0000, ir[15:0]};

  assign imem_addr  = pc;
  assign dmem_addr  = ADDR_W'(alu_out);
  assign dmem_wdata = b_reg;

  // Register reads: r0 and indices beyond the implemented file read as zero.
  logic [31:0] rs_val;
  logic [31:0] rt_val;

  always_comb begin
    rs_val = '0;
    rt_val = '0;
    if (rs != 5'd0 && int'(rs) < NUM_REGS) rs_val = rf[rs[RW-1:0]];
    if (rt != 5'd0 && int'(rt) < NUM_REGS) rt_val = rf[rt[RW-1:0]];
  end

  logic legal;

  always_comb begin
    legal = 1'b0;
    case (opcode)
      OP_RTYPE: legal = funct inside {F_ADD, F_SUB, F_AND, F_OR, F_SRL};
      OP_ADDI, OP_ORI, OP_LW, OP_SW, OP_BEQ, OP_J: legal = 1'b1;
      OP_BNE:   legal = BNE_EN;
      default:  legal = 1'b0;
    endcase
  end

  logic [31:0] alu_res;

  always_comb begin
    alu_res = '0;
    case (opcode)
      OP_RTYPE: begin
        case (funct)
          F_ADD:   alu_res = a_reg + b_reg;
          F_SUB:   alu_res = a_reg - b_reg;
          F_AND:   alu_res = a_reg & b_reg;
          F_OR:    alu_res = a_reg | b_reg;
          F_SRL:   alu_res = b_reg >> shamt;
          default: alu_res = '0;
        endcase
      end
      OP_ADDI, OP_LW, OP_SW: alu_res = a_reg + sext_imm;
      OP_ORI:                alu_res = a_reg | zext_imm;
      default:               alu_res = '0;
    endcase
  end

  logic [ADDR_W-1:0]  pc4;
  logic signed [31:0] br_off;
  logic [ADDR_W-1:0]  br_target;
  logic [27:0]        j_low;
  logic [ADDR_W-1:0]  j_target;
  logic               br_taken;

  assign pc4       = pc + ADDR_W'(4);
  assign br_off    = {{14{ir[15]}}, ir[15:0], 2'b00};
  assign br_target = pc4 + ADDR_W'(br_off);
  assign j_low     = {ir[25:0], 2'b00};
  assign br_taken  = (opcode == OP_BEQ) ? (a_reg == b_reg) : (a_reg != b_reg);

  // Jump keeps pc+4 bits above bit 27; narrower PCs simply truncate the field.
  always_comb begin
    j_target = pc4;
    for (int i = 0; i < ADDR_W && i < 28; i++) j_target[i] = j_low[i];
  end

  logic [4:0]  wb_idx;
  logic        wb_ok;
  logic [31:0] wb_data;

  assign wb_idx  = (opcode == OP_RTYPE) ? rd : rt;
  assign wb_ok   = (wb_idx != 5'd0) && (int'(wb_idx) < NUM_REGS);
  assign wb_data = (opcode == OP_LW) ? mdr : alu_out;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_FETCH;
      pc       <= RESET_PC;
      ir       <= '0;
      a_reg    <= '0;
      b_reg    <= '0;
      alu_out  <= '0;
      mdr      <= '0;
      imem_req <= 1'b0;
      dmem_req <= 1'b0;
      dmem_we  <= 1'b0;
      retire   <= 1'b0;
      halted   <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) rf[i] <= '0;
    end else begin
      retire <= 1'b0;
      case (state)
        S_FETCH: begin
          // Only the first fetch after reset arrives here with the request low.
          if (!imem_req) begin
            imem_req <= 1'b1;
          end else if (imem_ack) begin
            ir       <= imem_rdata;
            imem_req <= 1'b0;
            state    <= S_DECODE;
          end
        end
        S_DECODE: begin
          a_reg <= rs_val;
          b_reg <= rt_val;
          if (!legal) begin
            halted <= 1'b1;
            state  <= S_HALT;
          end else begin
            state <= S_EXEC;
          end
        end
        S_EXEC: begin
          alu_out <= alu_res;
          if (opcode == OP_BEQ || opcode == OP_BNE) begin
            pc       <= br_taken ? br_target : pc4;
            retire   <= 1'b1;
            imem_req <= 1'b1;
            state    <= S_FETCH;
          end else if (opcode == OP_J) begin
            pc       <= j_target;
            retire   <= 1'b1;
            imem_req <= 1'b1;
            state    <= S_FETCH;
          end else if (opcode == OP_LW || opcode == OP_SW) begin
            dmem_req <= 1'b1;
            dmem_we  <= (opcode == OP_SW);
            state    <= S_MEM;
          end else begin
            state <= S_WB;
          end
        end
        S_MEM: begin
          if (dmem_ack) begin
            dmem_req <= 1'b0;
            dmem_we  <= 1'b0;
            if (dmem_we) begin
              pc       <= pc4;
              retire   <= 1'b1;
              imem_req <= 1'b1;
              state    <= S_FETCH;
            end else begin
              mdr   <= dmem_rdata;
              state <= S_WB;
            end
          end
        end
        S_WB: begin
          if (wb_ok) rf[wb_idx[RW-1:0]] <= wb_data;
          pc       <= pc4;
          retire   <= 1'b1;
          imem_req <= 1'b1;
          state    <= S_FETCH;
        end
        S_HALT: begin
          halted <= 1'b1;
        end
        default: begin
          halted <= 1'b1;
          state  <= S_HALT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_cpu.sv
// Directed bench for multicycle_cpu: bench-side memories with programmable ack
// delay, a NUM_REGS=8 twin running in lockstep, and hand-computed expectations.
module tb_multicycle_cpu;

  localparam logic [31:0] HALT_W = 32'hFC000000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req, dmem_req, dmem_we, retire, halted;
  logic [31:0] imem_addr, dmem_addr, dmem_wdata, pc;
  logic        imem_ack = 1'b0;
  logic        dmem_ack = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic [31:0] dmem_rdata = '0;

  logic        imem_req8, dmem_req8, dmem_we8, retire8, halted8;
  logic [31:0] imem_addr8, dmem_addr8, dmem_wdata8, pc8;

  always #5 clk = ~clk;

  multicycle_cpu dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .pc(pc), .retire(retire), .halted(halted)
  );

  multicycle_cpu #(.NUM_REGS(8)) dut8 (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req8), .imem_addr(imem_addr8), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .dmem_req(dmem_req8), .dmem_we(dmem_we8), .dmem_addr(dmem_addr8), .dmem_wdata(dmem_wdata8),
    .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .pc(pc8), .retire(retire8), .halted(halted8)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  logic [31:0] imem [128];
  logic [31:0] dmem [64];
  int          imem_delay = 0;
  int          dmem_delay = 0;

  logic [31:0] fetch_log [$];
  logic [31:0] retire_log [$];
  logic [31:0] acc_len [$];
  logic [31:0] acc_addr [$];
  logic [31:0] acc_wdata [$];
  logic [31:0] acc_we [$];
  logic [31:0] w8_log [$];
  int          cyc = 0;
  int          i_wait = 0;
  int          d_wait = 0;
  int          d_len = 0;
  logic [31:0] d_addr0, d_wdata0;
  int          d_unstable = 0;
  int          req_after_halt = 0;

  // Memory responders and monitor, all on the falling edge.
  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      imem_ack = 1'b0;
      dmem_ack = 1'b0;
      i_wait = 0;
      d_wait = 0;
      d_len = 0;
    end else begin
      if (retire) retire_log.push_back(32'(cyc));
      if (halted && (imem_req || dmem_req)) req_after_halt++;
      if (imem_req) begin
        if (i_wait >= imem_delay) begin
          imem_ack = 1'b1;
          imem_rdata = imem[imem_addr[8:2]];
          fetch_log.push_back(imem_addr);
          i_wait = 0;
        end else begin
          imem_ack = 1'b0;
          i_wait++;
        end
      end else begin
        imem_ack = 1'b0;
        i_wait = 0;
      end
      if (dmem_req) begin
        if (d_len == 0) begin
          d_addr0 = dmem_addr;
          d_wdata0 = dmem_wdata;
        end else if (dmem_addr !== d_addr0 || dmem_wdata !== d_wdata0) begin
          d_unstable++;
        end
        d_len++;
        if (d_wait >= dmem_delay) begin
          dmem_ack = 1'b1;
          acc_len.push_back(32'(d_len));
          acc_addr.push_back(dmem_addr);
          acc_wdata.push_back(dmem_wdata);
          acc_we.push_back({31'd0, dmem_we});
          if (dmem_we) begin
            dmem[dmem_addr[7:2]] = dmem_wdata;
            if (dmem_req8 && dmem_we8) w8_log.push_back(dmem_wdata8);
          end else begin
            dmem_rdata = dmem[dmem_addr[7:2]];
          end
          d_wait = 0;
          d_len = 0;
        end else begin
          dmem_ack = 1'b0;
          d_wait++;
        end
      end else begin
        dmem_ack = 1'b0;
        d_wait = 0;
        d_len = 0;
      end
    end
  end

  function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [4:0] sh,
                                        input logic [5:0] fn);
    return {6'h00, rs, rt, rd, sh, fn};
  endfunction

  function automatic logic [31:0] enc_j(input logic [25:0] target);
    return {6'h02, target};
  endfunction

  function automatic logic [31:0] at(input logic [31:0] q[$], input int i);
    if (i < 0 || i >= q.size()) return 32'hFFFF_FFFF;
    return q[i];
  endfunction

  function automatic logic [31:0] lat(input int k);
    if (k < 1 || k >= retire_log.size()) return 32'hFFFF_FFFF;
    return retire_log[k] - retire_log[k-1];
  endfunction

  task automatic clear_mem();
    for (int i = 0; i < 128; i++) imem[i] = HALT_W;
    for (int i = 0; i < 64; i++) dmem[i] = '0;
  endtask

  task automatic clear_logs();
    fetch_log.delete();
    retire_log.delete();
    acc_len.delete();
    acc_addr.delete();
    acc_wdata.delete();
    acc_we.delete();
    w8_log.delete();
    d_unstable = 0;
    req_after_halt = 0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clear_logs();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic run(input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (halted) break;
    end
    #1;
  endtask

  initial begin
    // Program A: addi/addi/add/halt, plus reset and first-fetch checks.
    clear_mem();
    imem[0] = enc_i(6'h08, 5'd0, 5'd1, 16'd5);
    imem[1] = enc_i(6'h08, 5'd0, 5'd2, 16'hFFFD);
    imem[2] = enc_r(5'd1, 5'd2, 5'd3, 5'd0, 6'h20);
    imem[3] = HALT_W;
    rst_n = 1'b0;
    clear_logs();
    repeat (2) @(negedge clk);
    check("rst_imem_req", {31'd0, imem_req}, 32'd0);
    check("rst_dmem_req", {31'd0, dmem_req}, 32'd0);
    check("rst_retire", {31'd0, retire}, 32'd0);
    check("rst_halted", {31'd0, halted}, 32'd0);
    check("rst_pc", pc, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    check("rel_imem_req", {31'd0, imem_req}, 32'd1);
    check("rel_imem_addr", imem_addr, 32'h0);
    check("rel_halted", {31'd0, halted}, 32'd0);
    run(200);
    check("a_first_fetch", at(fetch_log, 0), 32'h0);
    check("a_halted", {31'd0, halted}, 32'd1);
    check("a_pc", pc, 32'hC);
    check("a_retires", 32'(retire_log.size()), 32'd3);

    // Program ALU: every ALU op, r0 write, results stored out for inspection.
    clear_mem();
    imem[0]  = enc_i(6'h08, 5'd0, 5'd1, 16'd5);
    imem[1]  = enc_i(6'h08, 5'd0, 5'd2, 16'hFFFD);
    imem[2]  = enc_r(5'd1, 5'd2, 5'd3, 5'd0, 6'h20);
    imem[3]  = enc_r(5'd1, 5'd2, 5'd4, 5'd0, 6'h22);
    imem[4]  = enc_r(5'd1, 5'd2, 5'd5, 5'd0, 6'h24);
    imem[5]  = enc_r(5'd1, 5'd2, 5'd6, 5'd0, 6'h25);
    imem[6]  = enc_i(6'h0D, 5'd1, 5'd7, 16'h8000);
    imem[7]  = enc_r(5'd0, 5'd2, 5'd8, 5'd4, 6'h02);
    imem[8]  = enc_i(6'h08, 5'd0, 5'd0, 16'd7);
    for (int k = 0; k < 6; k++) imem[9+k] = enc_i(6'h2B, 5'd0, 5'(3+k), 16'(4*k));
    imem[15] = enc_i(6'h2B, 5'd0, 5'd0, 16'd24);
    imem[16] = HALT_W;
    do_reset();
    dmem[6] = 32'hDEAD;
    run(300);
    check("alu_add", dmem[0], 32'h2);
    check("alu_sub", dmem[1], 32'h8);
    check("alu_and", dmem[2], 32'h5);
    check("alu_or", dmem[3], 32'hFFFF_FFFD);
    check("alu_ori", dmem[4], 32'h8005);
    check("alu_srl", dmem[5], 32'h0FFF_FFFF);
    check("alu_r0", dmem[6], 32'h0);
    check("alu_retires", 32'(retire_log.size()), 32'd16);
    check("alu_pc", pc, 32'h40);
    check("alu_lat_addi", lat(1), 32'd4);
    check("alu_lat_sw", lat(9), 32'd4);

    // Same program with one cycle of fetch ack delay.
    imem_delay = 1;
    do_reset();
    run(400);
    check("idly_lat_addi", lat(1), 32'd5);
    check("idly_sub", dmem[1], 32'h8);
    imem_delay = 0;

    // Program MEM: sw then lw with three cycles of data ack delay.
    clear_mem();
    imem[0] = enc_i(6'h08, 5'd0, 5'd1, 16'd5);
    imem[1] = enc_i(6'h2B, 5'd0, 5'd1, 16'd8);
    imem[2] = enc_i(6'h23, 5'd0, 5'd4, 16'd8);
    imem[3] = enc_i(6'h2B, 5'd0, 5'd4, 16'd12);
    dmem_delay = 3;
    do_reset();
    run(200);
    check("mem_accesses", 32'(acc_len.size()), 32'd3);
    check("mem_sw_len", at(acc_len, 0), 32'd4);
    check("mem_sw_we", at(acc_we, 0), 32'd1);
    check("mem_sw_addr", at(acc_addr, 0), 32'd8);
    check("mem_sw_wdata", at(acc_wdata, 0), 32'd5);
    check("mem_lw_len", at(acc_len, 1), 32'd4);
    check("mem_lw_we", at(acc_we, 1), 32'd0);
    check("mem_lw_addr", at(acc_addr, 1), 32'd8);
    check("mem_r4", dmem[3], 32'd5);
    check("mem_lat_sw", lat(1), 32'd7);
    check("mem_lat_lw", lat(2), 32'd8);
    check("mem_stable", 32'(d_unstable), 32'd0);
    dmem_delay = 0;

    // Program R9: r9 exists only in the 32-register build.
    clear_mem();
    imem[0] = enc_i(6'h08, 5'd0, 5'd9, 16'd7);
    imem[1] = enc_i(6'h2B, 5'd0, 5'd9, 16'd0);
    imem[2] = enc_i(6'h08, 5'd0, 5'd7, 16'd3);
    imem[3] = enc_i(6'h2B, 5'd0, 5'd7, 16'd4);
    do_reset();
    run(200);
    check("r9_main", dmem[0], 32'd7);
    check("r9_small", at(w8_log, 0), 32'd0);
    check("r7_small", at(w8_log, 1), 32'd3);

    // Program BR: j, not-taken beq, taken beq, then a beq-to-self loop.
    clear_mem();
    imem[0]  = enc_i(6'h08, 5'd0, 5'd1, 16'd5);
    imem[1]  = enc_i(6'h08, 5'd0, 5'd2, 16'd1);
    imem[2]  = enc_j(26'h40);
    imem[64] = enc_i(6'h04, 5'd1, 5'd2, 16'd3);
    imem[65] = enc_i(6'h04, 5'd1, 5'd1, 16'd2);
    imem[68] = enc_j(26'h4);
    imem[4]  = enc_i(6'h04, 5'd1, 5'd1, 16'hFFFF);
    do_reset();
    run(40);
    check("br_halted", {31'd0, halted}, 32'd0);
    check("br_j_target", at(fetch_log, 3), 32'h100);
    check("br_not_taken", at(fetch_log, 4), 32'h104);
    check("br_taken", at(fetch_log, 5), 32'h110);
    check("br_j_back", at(fetch_log, 6), 32'h10);
    check("br_self", at(fetch_log, 7), 32'h10);
    check("br_self2", at(fetch_log, 8), 32'h10);
    check("br_lat", lat(retire_log.size() - 1), 32'd3);

    // Program ILL: opcode 0x3E halts after DECODE with no further fetches.
    clear_mem();
    imem[0] = enc_i(6'h08, 5'd0, 5'd1, 16'd5);
    imem[1] = {6'h3E, 26'd0};
    do_reset();
    run(100);
    repeat (10) @(negedge clk);
    #1;
    check("ill_halted", {31'd0, halted}, 32'd1);
    check("ill_pc", pc, 32'h4);
    check("ill_retires", 32'(retire_log.size()), 32'd1);
    check("ill_fetches", 32'(fetch_log.size()), 32'd2);
    check("ill_no_req", 32'(req_after_halt), 32'd0);

    // Program BNE: legal only with the optional feature.
    clear_mem();
    imem[0] = enc_i(6'h08, 5'd0, 5'd1, 16'd5);
    imem[1] = enc_i(6'h05, 5'd1, 5'd0, 16'd1);
    do_reset();
    run(100);
`ifdef MCPU_BNE_EN
    check("bne_pc", pc, 32'hC);
    check("bne_retires", 32'(retire_log.size()), 32'd2);
`else
    check("bne_pc", pc, 32'h4);
    check("bne_retires", 32'(retire_log.size()), 32'd1);
`endif

    // Reset asserted while a load is waiting for its ack.
    clear_mem();
    imem[0] = enc_i(6'h08, 5'd0, 5'd1, 16'd5);
    imem[1] = enc_i(6'h23, 5'd0, 5'd2, 16'd0);
    dmem_delay = 50;
    do_reset();
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (dmem_req) break;
    end
    check("mid_req_seen", {31'd0, dmem_req}, 32'd1);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_dmem_req", {31'd0, dmem_req}, 32'd0);
    check("mid_pc", pc, 32'h0);
    check("mid_imem_req", {31'd0, imem_req}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    dmem_delay = 0;
    repeat (2) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
